// File: rtl/adc_scan_driver_if.sv
// Application-side bus of adc_scan_driver: scan control in, channel-tagged results out.
interface adc_scan_driver_if #(
  parameter int NUM_CH   = 8,
  parameter int RES_BITS = 12
);
  logic                start;
  logic                continuous;
  logic [NUM_CH-1:0]   ch_mask;
  logic                busy;
  logic [RES_BITS-1:0] sample_data;
  logic [2:0]          sample_ch;
  logic                sample_valid;
  logic                scan_done;

  modport master (
    output start, continuous, ch_mask,
    input  busy, sample_data, sample_ch, sample_valid, scan_done
  );

  modport slave (
    input  start, continuous, ch_mask,
    output busy, sample_data, sample_ch, sample_valid, scan_done
  );
endinterface

// File: rtl/adc_scan_driver.sv
// Scanning SPI master for ADC128S102-family converters: one CS-low burst per channel mask.
// Optional ADC_SCAN_ZERO_CHECK_EN adds frame_err_o, flagging a 1 in any leading bit b=0..3.
module adc_scan_driver #(
  parameter int CLK_DIV  = 2,
  parameter int RES_BITS = 12,
  parameter int NUM_CH   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  adc_scan_driver_if.slave bus,
  output logic             cs_n_o,
  output logic             sclk_o,
  output logic             din_o,
  input  logic             dout_i
`ifdef ADC_SCAN_ZERO_CHECK_EN
  ,
  output logic             frame_err_o
`endif
);

  localparam int CNT_W = $clog2(2 * CLK_DIV) + 1;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t DIV_LAST = cnt_t'(CLK_DIV - 1);
  localparam cnt_t GAP_LAST = cnt_t'(2 * CLK_DIV - 1);

`ifdef ADC_SCAN_ZERO_CHECK_EN
  localparam int SHIFT_W = 15;  // b0..b14 kept so the leading bits can be inspected
`else
  localparam int SHIFT_W = 11;  // only D11..D1 are ever needed
`endif

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_e;

  state_e              state_q;
  cnt_t                cnt_q;
  logic [4:0]          half_q;
  logic [3:0]          frame_q;
  logic [3:0]          nframes_q;
  logic [NUM_CH-1:0]   mask_q;
  logic [2:0]          addr_q;
  logic [2:0]          data_ch_q;
  logic [SHIFT_W-1:0]  shift_q;
  logic                cs_n_q, sclk_q, din_q, busy_q, valid_q, done_q;
  logic [RES_BITS-1:0] data_q;
  logic [2:0]          ch_q;
`ifdef ADC_SCAN_ZERO_CHECK_EN
  logic                err_q;
`endif

  function automatic logic [3:0] count_ch(input logic [NUM_CH-1:0] m);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < NUM_CH; i++) n = n + 4'(m[i]);
    return n;
  endfunction

  // Next enabled channel above cur, wrapping to the lowest; cur=7 yields the lowest.
  function automatic logic [2:0] next_ch(input logic [NUM_CH-1:0] m, input logic [2:0] cur);
    logic [2:0] first, nxt;
    logic       found;
    first = '0;
    nxt   = '0;
    found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) begin
        first = 3'(i);
        if (i > int'(cur)) begin
          nxt   = 3'(i);
          found = 1'b1;
        end
      end
    end
    return found ? nxt : first;
  endfunction

  logic [11:0] data_word;
  logic [3:0]  next_bit;
  logic        din_next;

  assign data_word = {shift_q[10:0], dout_i};
  assign next_bit  = half_q[4:1] + 4'd1;

  // NOTE: combinational blocks assign a default first so no path leaves din_next held (no latch).
  always_comb begin
    din_next = 1'b0;
    case (next_bit)
      4'd2:    din_next = addr_q[2];
      4'd3:    din_next = addr_q[1];
      4'd4:    din_next = addr_q[0];
      default: din_next = 1'b0;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every read sees last cycle's value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      half_q    <= '0;
      frame_q   <= '0;
      nframes_q <= '0;
      mask_q    <= '0;
      addr_q    <= '0;
      data_ch_q <= '0;
      shift_q   <= '0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b1;
      din_q     <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      data_q    <= '0;
      ch_q      <= '0;
`ifdef ADC_SCAN_ZERO_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef ADC_SCAN_ZERO_CHECK_EN
      err_q   <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (bus.start && bus.ch_mask != '0) begin
            mask_q    <= bus.ch_mask;
            nframes_q <= count_ch(bus.ch_mask);
            addr_q    <= next_ch(bus.ch_mask, 3'd7);
            frame_q   <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            cs_n_q    <= 1'b0;
            state_q   <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (cnt_q == DIV_LAST) begin
            cnt_q   <= '0;
            half_q  <= '0;
            sclk_q  <= 1'b0;
            din_q   <= 1'b0;
            state_q <= S_SHIFT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_SHIFT: begin
          if (cnt_q != DIV_LAST) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            cnt_q <= '0;
            if (!half_q[0]) begin
              // Low half ends: SCLK rises and dout is captured on this edge.
              sclk_q  <= 1'b1;
              shift_q <= {shift_q[SHIFT_W-2:0], dout_i};
              half_q  <= half_q + 5'd1;
              if (half_q == 5'd30 && frame_q != '0) begin
                valid_q <= 1'b1;
                data_q  <= data_word[11 -: RES_BITS];
                ch_q    <= data_ch_q;
`ifdef ADC_SCAN_ZERO_CHECK_EN
                err_q   <= |shift_q[14:11];
`endif
              end
            end else if (half_q == 5'd31 && frame_q == nframes_q) begin
              state_q <= S_HOLD;
            end else begin
              sclk_q <= 1'b0;
              din_q  <= din_next;
              half_q <= half_q + 5'd1;
              if (half_q == 5'd31) begin
                frame_q   <= frame_q + 4'd1;
                data_ch_q <= addr_q;
                addr_q    <= next_ch(mask_q, addr_q);
              end
            end
          end
        end

        S_HOLD: begin
          if (cnt_q == DIV_LAST) begin
            cnt_q  <= '0;
            cs_n_q <= 1'b1;
            done_q <= 1'b1;
            if (bus.continuous) begin
              mask_q    <= bus.ch_mask;
              nframes_q <= count_ch(bus.ch_mask);
              addr_q    <= next_ch(bus.ch_mask, 3'd7);
              state_q   <= S_GAP;
            end else begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q   <= '0;
            frame_q <= '0;
            if (mask_q != '0) begin
              cs_n_q  <= 1'b0;
              state_q <= S_SETUP;
            end else begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cs_n_o           = cs_n_q;
  assign sclk_o           = sclk_q;
  assign din_o            = din_q;
  assign bus.busy         = busy_q;
  assign bus.sample_valid = valid_q;
  assign bus.sample_data  = data_q;
  assign bus.sample_ch    = ch_q;
  assign bus.scan_done    = done_q;
`ifdef ADC_SCAN_ZERO_CHECK_EN
  assign frame_err_o      = err_q;
`endif

endmodule

// File: tb/tb_adc_scan_driver.sv
// Bench for adc_scan_driver: behavioural ADC model on the pins plus a sample/timing monitor.
`timescale 1ns/1ps
module tb_adc_scan_driver;
  localparam int CLK_DIV  = 2;
  localparam int RES_BITS = 12;
  localparam int NUM_CH   = 8;
  localparam int TIMEOUT  = 4000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adc_scan_driver_if #(.NUM_CH(NUM_CH), .RES_BITS(RES_BITS)) bus ();
  adc_scan_driver_if #(.NUM_CH(8), .RES_BITS(8)) bus8 ();

  logic cs_n, sclk, din;
  logic dout = 1'b0;
  logic cs8_n, sclk8, din8;
  logic dout8 = 1'b0;
`ifdef ADC_SCAN_ZERO_CHECK_EN
  logic frame_err, frame_err8;
`endif

  adc_scan_driver #(.CLK_DIV(CLK_DIV), .RES_BITS(RES_BITS), .NUM_CH(NUM_CH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .cs_n_o(cs_n), .sclk_o(sclk), .din_o(din), .dout_i(dout)
`ifdef ADC_SCAN_ZERO_CHECK_EN
    , .frame_err_o(frame_err)
`endif
  );

  adc_scan_driver #(.CLK_DIV(1), .RES_BITS(8), .NUM_CH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8.slave),
    .cs_n_o(cs8_n), .sclk_o(sclk8), .din_o(din8), .dout_i(dout8)
`ifdef ADC_SCAN_ZERO_CHECK_EN
    , .frame_err_o(frame_err8)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- ADC model (main DUT): one-frame address pipeline ----------------
  logic [11:0] ch_val [NUM_CH];
  logic        lead_inject = 1'b0;
  int          m_bit = 0;
  logic [15:0] m_word = '0;
  logic [2:0]  m_addr = '0;
  int          addr_log[$];
  logic        p_sclk = 1'b1, p_cs = 1'b1;

  always @(negedge clk) begin
    if (p_cs && !cs_n) begin
      m_bit  = 0;
      m_word = {4'b0000, 12'($urandom)};
      addr_log.delete();
    end
    if (!cs_n && p_sclk && !sclk) dout = m_word[15 - m_bit];
    if (!cs_n && !p_sclk && sclk) begin
      if (m_bit >= 2 && m_bit <= 4) m_addr[4 - m_bit] = din;
      m_bit++;
      if (m_bit == 16) begin
        addr_log.push_back(int'(m_addr));
        m_word = {(lead_inject ? 4'b0100 : 4'b0000), ch_val[m_addr]};
        m_bit  = 0;
      end
    end
    p_cs   = cs_n;
    p_sclk = sclk;
  end

  // ---------------- monitor (main DUT) ----------------
  int got_ch[$], got_data[$], low_q[$], gap_q[$];
  int done_cnt = 0, low_cnt = 0, high_cnt = 0, sv_bad = 0, done_bad = 0;
  int cyc = 0, last_sv = -100000;
  int err_with_sv = 0, err_alone = 0;

  always @(negedge clk) begin
    cyc++;
    if (bus.sample_valid === 1'b1) begin
      got_ch.push_back(int'(bus.sample_ch));
      got_data.push_back(int'(bus.sample_data));
      if (sclk !== 1'b1 || cs_n !== 1'b0 || cyc - last_sv < 32 * CLK_DIV) sv_bad++;
      last_sv = cyc;
    end
    if (bus.scan_done === 1'b1) begin
      done_cnt++;
      if (cs_n !== 1'b1) done_bad++;
    end
    if (cs_n === 1'b0) begin
      if (high_cnt > 0) gap_q.push_back(high_cnt);
      high_cnt = 0;
      low_cnt++;
    end else begin
      if (low_cnt > 0) low_q.push_back(low_cnt);
      low_cnt = 0;
      high_cnt++;
    end
`ifdef ADC_SCAN_ZERO_CHECK_EN
    if (frame_err === 1'b1) begin
      if (bus.sample_valid === 1'b1) err_with_sv++;
      else err_alone++;
    end
`endif
  end

  // ---------------- ADC model + monitor (8-bit DUT, always converts 12'hABC) ----------------
  logic [15:0] w8 = 16'h0ABC;
  int          b8 = 0;
  logic        p_sclk8 = 1'b1;
  int          g8_ch[$], g8_data[$];

  always @(negedge clk) begin
    if (cs8_n) b8 = 0;
    else begin
      if (p_sclk8 && !sclk8) dout8 = w8[15 - b8];
      if (!p_sclk8 && sclk8) b8 = (b8 + 1) % 16;
    end
    if (bus8.sample_valid === 1'b1) begin
      g8_ch.push_back(int'(bus8.sample_ch));
      g8_data.push_back(int'(bus8.sample_data));
    end
    p_sclk8 = sclk8;
  end

  // ---------------- reference model ----------------
  function automatic logic [127:0] exp_samples(input logic [NUM_CH-1:0] m);
    logic [127:0] s = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (m[i]) s = {s[111:0], 1'b1, 3'(i), 12'(ch_val[i] >> (12 - RES_BITS))};
    return s;
  endfunction

  function automatic logic [127:0] got_samples();
    logic [127:0] s = '0;
    foreach (got_ch[k]) s = {s[111:0], 1'b1, 3'(got_ch[k]), 12'(got_data[k])};
    return s;
  endfunction

  function automatic logic [63:0] exp_addrs(input logic [NUM_CH-1:0] m);
    logic [63:0] s = '0;
    int first = -1;
    for (int i = 0; i < NUM_CH; i++)
      if (m[i]) begin
        s = {s[59:0], 1'b1, 3'(i)};
        if (first < 0) first = i;
      end
    if (first >= 0) s = {s[59:0], 1'b1, 3'(first)};
    return s;
  endfunction

  function automatic logic [63:0] got_addrs();
    logic [63:0] s = '0;
    foreach (addr_log[k]) s = {s[59:0], 1'b1, 3'(addr_log[k])};
    return s;
  endfunction

  function automatic int exp_low(input logic [NUM_CH-1:0] m);
    return CLK_DIV * (32 * ($countones(m) + 1) + 2);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic clear_mon();
    got_ch.delete(); got_data.delete(); low_q.delete(); gap_q.delete();
    done_cnt = 0; err_with_sv = 0; err_alone = 0;
  endtask

  task automatic pulse_start(input logic [NUM_CH-1:0] m);
    @(posedge clk); #1;
    bus.ch_mask = m;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start   = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int c = 0;
    while (bus.busy === 1'b1 && c < TIMEOUT) begin
      @(posedge clk); #1;
      c++;
    end
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s timeout: busy=%b after %0d cycles, want 0", name, bus.busy, c);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  function automatic logic [20:0] out_vec();
    return {cs_n, sclk, din, bus.busy, bus.sample_valid, bus.scan_done, bus.sample_ch, bus.sample_data};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if (out_vec() !== {6'b110000, 3'd0, 12'd0}) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want %h", out_vec(), {6'b110000, 3'd0, 12'd0});
    end
`ifdef ADC_SCAN_ZERO_CHECK_EN
    n_cmp++;
    if (frame_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_frame_err: got %b want 0", frame_err);
    end
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_single();
    logic s1, s2;
    clear_mon();
    ch_val[0] = 12'hABC;
    pulse_start(8'h01);
    n_cmp++;
    if ({cs_n, bus.busy, sclk} !== 3'b011) begin
      n_err++;
      $display("FAIL start_latency: cs_n/busy/sclk got %b want 011", {cs_n, bus.busy, sclk});
    end
    @(posedge clk); #1; s1 = sclk;
    @(posedge clk); #1; s2 = sclk;
    n_cmp++;
    if ({s1, s2} !== 2'b10) begin
      n_err++;
      $display("FAIL first_sclk_fall: got %b want 10", {s1, s2});
    end
    wait_idle("single");
    n_cmp++;
    if (got_samples() !== exp_samples(8'h01)) begin
      n_err++;
      $display("FAIL single_samples: got %h want %h", got_samples(), exp_samples(8'h01));
    end
    n_cmp++;
    if (got_addrs() !== exp_addrs(8'h01)) begin
      n_err++;
      $display("FAIL single_addrs: got %h want %h", got_addrs(), exp_addrs(8'h01));
    end
    n_cmp++;
    if (low_q.size() != 1 || low_q[0] != 132 || done_cnt != 1) begin
      n_err++;
      $display("FAIL single_cs_low: got n=%0d len=%0d done=%0d want n=1 len=132 done=1",
               low_q.size(), (low_q.size() > 0) ? low_q[0] : -1, done_cnt);
    end
  endtask

  task automatic test_mask_a4();
    clear_mon();
    for (int i = 0; i < NUM_CH; i++) ch_val[i] = 12'(i * 'h111);
    pulse_start(8'hA4);
    wait_idle("mask_a4");
    n_cmp++;
    if (got_samples() !== exp_samples(8'hA4)) begin
      n_err++;
      $display("FAIL a4_samples: got %h want %h", got_samples(), exp_samples(8'hA4));
    end
    n_cmp++;
    if (got_addrs() !== exp_addrs(8'hA4)) begin
      n_err++;
      $display("FAIL a4_addrs: got %h want %h", got_addrs(), exp_addrs(8'hA4));
    end
    n_cmp++;
    if (low_q.size() != 1 || low_q[0] != 260) begin
      n_err++;
      $display("FAIL a4_cs_low: got n=%0d len=%0d want n=1 len=260",
               low_q.size(), (low_q.size() > 0) ? low_q[0] : -1);
    end
  endtask

  task automatic test_busy_ignore();
    clear_mon();
    pulse_start(8'hA4);
    repeat (100) @(posedge clk);
    pulse_start(8'hFF);
    wait_idle("busy_ignore");
    n_cmp++;
    if (got_samples() !== exp_samples(8'hA4) || done_cnt != 1) begin
      n_err++;
      $display("FAIL busy_ignore: got %h done=%0d want %h done=1", got_samples(), done_cnt,
               exp_samples(8'hA4));
    end
  endtask

  task automatic test_empty_mask();
    clear_mon();
    pulse_start(8'h00);
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL empty_busy: got %b want 0", bus.busy);
    end
    repeat (50) @(posedge clk);
    #1;
    n_cmp++;
    if (low_q.size() != 0 || low_cnt != 0 || got_ch.size() != 0 || done_cnt != 0) begin
      n_err++;
      $display("FAIL empty_activity: cs_low=%0d/%0d samples=%0d done=%0d want 0/0/0/0",
               low_q.size(), low_cnt, got_ch.size(), done_cnt);
    end
  endtask

  task automatic test_continuous();
    logic [127:0] e;
    int c = 0, bad_low = 0, bad_gap = 0;
    clear_mon();
    for (int i = 0; i < NUM_CH; i++) ch_val[i] = 12'($urandom);
    e = exp_samples(8'h03);
    bus.continuous = 1'b1;
    pulse_start(8'h03);
    while (done_cnt < 3 && c < 3 * TIMEOUT) begin
      @(posedge clk); #1;
      c++;
    end
    repeat (50) @(posedge clk);
    #1;
    bus.continuous = 1'b0;
    wait_idle("continuous");
    foreach (low_q[k]) if (low_q[k] != exp_low(8'h03)) bad_low++;
    for (int k = 1; k < gap_q.size(); k++) if (gap_q[k] != 2 * CLK_DIV) bad_gap++;
    n_cmp++;
    if (done_cnt != 4 || low_q.size() != 4 || bad_low != 0) begin
      n_err++;
      $display("FAIL cont_scans: done=%0d scans=%0d bad_len=%0d want 4/4/0",
               done_cnt, low_q.size(), bad_low);
    end
    n_cmp++;
    if (gap_q.size() != 4 || bad_gap != 0) begin
      n_err++;
      $display("FAIL cont_gap: gaps=%0d bad=%0d want 4/0", gap_q.size(), bad_gap);
    end
    n_cmp++;
    if (got_samples() !== {e[31:0], e[31:0], e[31:0], e[31:0]}) begin
      n_err++;
      $display("FAIL cont_samples: got %h want %h", got_samples(), {e[31:0], e[31:0], e[31:0], e[31:0]});
    end
  endtask

  task automatic test_random();
    logic [NUM_CH-1:0] m;
    for (int it = 0; it < 8; it++) begin
      clear_mon();
      m = NUM_CH'($urandom_range(1, 255));
      for (int i = 0; i < NUM_CH; i++) ch_val[i] = 12'($urandom);
      pulse_start(m);
      wait_idle("random");
      n_cmp++;
      if (got_samples() !== exp_samples(m)) begin
        n_err++;
        $display("FAIL rand_samples mask=%h: got %h want %h", m, got_samples(), exp_samples(m));
      end
      n_cmp++;
      if (got_addrs() !== exp_addrs(m)) begin
        n_err++;
        $display("FAIL rand_addrs mask=%h: got %h want %h", m, got_addrs(), exp_addrs(m));
      end
      n_cmp++;
      if (low_q.size() != 1 || low_q[0] != exp_low(m)) begin
        n_err++;
        $display("FAIL rand_cs_low mask=%h: got n=%0d len=%0d want n=1 len=%0d", m, low_q.size(),
                 (low_q.size() > 0) ? low_q[0] : -1, exp_low(m));
      end
    end
  endtask

  task automatic test_reset_mid();
    int c = 0;
    clear_mon();
    pulse_start(8'hFF);
    while (addr_log.size() < 1 && c < TIMEOUT) begin
      @(posedge clk); #1;
      c++;
    end
    repeat (20) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_vec() !== {6'b110000, 3'd0, 12'd0}) begin
      n_err++;
      $display("FAIL reset_mid_outputs: got %h want %h", out_vec(), {6'b110000, 3'd0, 12'd0});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    clear_mon();
    ch_val[4] = 12'h5A3;
    pulse_start(8'h10);
    wait_idle("after_reset");
    n_cmp++;
    if (got_samples() !== exp_samples(8'h10) || low_q.size() != 1 || low_q[0] != exp_low(8'h10)) begin
      n_err++;
      $display("FAIL after_reset_scan: got %h n=%0d want %h n=1", got_samples(), low_q.size(),
               exp_samples(8'h10));
    end
  endtask

  task automatic test_res8();
    logic [21:0] g;
    int c = 0;
    g = '0;
    @(posedge clk); #1;
    bus8.ch_mask = 8'h81;
    bus8.start   = 1'b1;
    @(posedge clk); #1;
    bus8.start   = 1'b0;
    while (bus8.busy === 1'b1 && c < TIMEOUT) begin
      @(posedge clk); #1;
      c++;
    end
    repeat (4) @(posedge clk);
    #1;
    foreach (g8_ch[k]) g = {g[10:0], 3'(g8_ch[k]), 8'(g8_data[k])};
    n_cmp++;
    if (g8_ch.size() != 2 || g !== {3'd0, 8'hAB, 3'd7, 8'hAB} || bus8.busy !== 1'b0) begin
      n_err++;
      $display("FAIL res8: n=%0d got %h busy=%b want n=2 %h busy=0", g8_ch.size(), g,
               bus8.busy, {3'd0, 8'hAB, 3'd7, 8'hAB});
    end
  endtask

`ifdef ADC_SCAN_ZERO_CHECK_EN
  task automatic test_zero_check();
    clear_mon();
    ch_val[0]   = 12'h3C5;
    lead_inject = 1'b1;
    pulse_start(8'h01);
    wait_idle("zero_check");
    lead_inject = 1'b0;
    n_cmp++;
    if (err_with_sv != 1 || err_alone != 0 || got_samples() !== exp_samples(8'h01)) begin
      n_err++;
      $display("FAIL frame_err: with_valid=%0d alone=%0d samples %h want 1/0 %h",
               err_with_sv, err_alone, got_samples(), exp_samples(8'h01));
    end
  endtask
`endif

  task automatic test_strobes();
    n_cmp++;
    if (sv_bad != 0 || done_bad != 0) begin
      n_err++;
      $display("FAIL strobe_timing: bad sample_valid=%0d bad scan_done=%0d want 0/0", sv_bad, done_bad);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.continuous = 1'b0; bus.ch_mask = '0;
    bus8.start = 1'b0; bus8.continuous = 1'b0; bus8.ch_mask = '0;
    for (int i = 0; i < NUM_CH; i++) ch_val[i] = '0;
    test_reset();
    test_single();
    test_mask_a4();
    test_busy_ignore();
    test_empty_mask();
    test_continuous();
    test_random();
    test_reset_mid();
    test_res8();
`ifdef ADC_SCAN_ZERO_CHECK_EN
    test_zero_check();
`endif
    test_strobes();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
